// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus arbiter.
// Contents:
//   - controller state encoding (state_t)
//   - slave id constants SLAVE0..SLAVE2 and SLAVE_NONE
//   - master/slave counts and the default grant timeout
//   - helpers converting between a 2-bit slave id and a one-hot select
package bus_pkg;

    localparam int unsigned NUM_MASTERS     = 2;
    localparam int unsigned NUM_SLAVES      = 3;
    localparam int unsigned DEFAULT_TIMEOUT = 64;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StAddr0,
        StAddr1,
        StRoute
    } state_t;

    localparam logic [1:0] SLAVE0     = 2'd0;
    localparam logic [1:0] SLAVE1     = 2'd1;
    localparam logic [1:0] SLAVE2     = 2'd2;
    localparam logic [1:0] SLAVE_NONE = 2'd3;

    // One-hot select for a decoded id; SLAVE_NONE selects nobody.
    function automatic logic [NUM_SLAVES-1:0] id_to_sel(input logic [1:0] id);
        logic [NUM_SLAVES-1:0] sel;
        sel = '0;
        case (id)
            SLAVE0:  sel = 3'b001;
            SLAVE1:  sel = 3'b010;
            SLAVE2:  sel = 3'b100;
            default: sel = '0;
        endcase
        return sel;
    endfunction

    // Index of the selected slave; only meaningful when sel is one-hot.
    function automatic logic [1:0] sel_to_id(input logic [NUM_SLAVES-1:0] sel);
        logic [1:0] id;
        id = SLAVE_NONE;
        case (sel)
            3'b001:  id = SLAVE0;
            3'b010:  id = SLAVE1;
            3'b100:  id = SLAVE2;
            default: id = SLAVE_NONE;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick, purely combinational.
// Ports:
//   req    in  [1:0]  request per master
//   last   in  1      master served most recently (register kept by parent)
//   winner out 1      master to grant
//   valid  out 1      at least one request present
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;  // contention: the one not served last
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, three-slave arbiter and router for the serial system bus.
// Grants one master at a time (round-robin on contention), decodes the target
// slave from the first two serial address bits after valid_s rises, forwards
// the granted master's serial lines to all slaves and returns the selected
// slave's response lines to the granted master only.
// Ports:
//   clock, reset                    clock and async active-high reset
//   m_bus_req                       per-master request
//   m_addr_tx/m_data_tx/m_valid_s/
//   m_write_en/m_burst_mode         per-master serial lines
//   m_bus_ready                     per-master registered grant (one-hot or 0)
//   m_data_rx/m_slave_ready/
//   m_slave_valid                   per-master return lines (0 for non-granted)
//   s_addr_tx/s_data_tx/s_valid_s/
//   s_write_en/s_burst_mode         broadcast of granted master's lines
//   s_sel                           registered one-hot slave select
//   s_data_rx/s_ready/s_valid_rsp   per-slave return lines
//   grant_id                        current or last granted master
//   timeout_err, decode_err         single-cycle error pulses
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_bus_req,
    input  logic [NUM_MASTERS-1:0] m_addr_tx,
    input  logic [NUM_MASTERS-1:0] m_data_tx,
    input  logic [NUM_MASTERS-1:0] m_valid_s,
    input  logic [NUM_MASTERS-1:0] m_write_en,
    input  logic [NUM_MASTERS-1:0] m_burst_mode,
    output logic [NUM_MASTERS-1:0] m_bus_ready,
    output logic [NUM_MASTERS-1:0] m_data_rx,
    output logic [NUM_MASTERS-1:0] m_slave_ready,
    output logic [NUM_MASTERS-1:0] m_slave_valid,
    output logic                   s_addr_tx,
    output logic                   s_data_tx,
    output logic                   s_valid_s,
    output logic                   s_write_en,
    output logic                   s_burst_mode,
    output logic [NUM_SLAVES-1:0]  s_sel,
    input  logic [NUM_SLAVES-1:0]  s_data_rx,
    input  logic [NUM_SLAVES-1:0]  s_ready,
    input  logic [NUM_SLAVES-1:0]  s_valid_rsp,
    output logic                   grant_id,
    output logic                   timeout_err,
    output logic                   decode_err
);

    localparam int unsigned TimerW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    grant_id_q, grant_id_d;
    logic                    last_q, last_d;
    logic [TimerW-1:0]       timer_q, timer_d;
    logic                    valid_prev_q, valid_prev_d;
    logic [NUM_MASTERS-1:0]  bus_ready_q, bus_ready_d;
    logic [NUM_SLAVES-1:0]   s_sel_q, s_sel_d;
    logic                    id_hi_q, id_hi_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    decode_err_q, decode_err_d;

    logic                    arb_winner;
    logic                    arb_valid;
    logic                    g_req;
    logic                    g_valid;
    logic                    g_addr;
    logic                    granted;
    logic                    route_active;
    logic [1:0]              sel_id;

    rr_arbiter2 u_rr_arbiter2 (
        .req    (m_bus_req),
        .last   (last_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    assign g_req   = m_bus_req[grant_id_q];
    assign g_valid = m_valid_s[grant_id_q];
    assign g_addr  = m_addr_tx[grant_id_q];

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_d        = last_q;
        timer_d       = timer_q;
        valid_prev_d  = 1'b0;
        bus_ready_d   = bus_ready_q;
        s_sel_d       = s_sel_q;
        id_hi_d       = id_hi_q;
        timeout_err_d = 1'b0;
        decode_err_d  = 1'b0;

        if (state_q != StIdle) begin
            valid_prev_d = g_valid;
        end

        if (state_q != StIdle && !g_req) begin
            // Release wins over every other transition, including timeout.
            state_d     = StIdle;
            bus_ready_d = '0;
            s_sel_d     = '0;
            last_d      = grant_id_q;
        end else begin
            case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        state_d             = StGrant;
                        grant_id_d          = arb_winner;
                        bus_ready_d         = '0;
                        bus_ready_d[arb_winner] = 1'b1;
                        timer_d             = '0;
                    end
                end
                StGrant: begin
                    if (g_valid) begin
                        state_d = StAddr0;
                    end else if (timer_q == TimerMax) begin
                        state_d       = StIdle;
                        bus_ready_d   = '0;
                        s_sel_d       = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StAddr0: begin
                    id_hi_d = g_addr;
                    state_d = StAddr1;
                end
                StAddr1: begin
                    state_d = StRoute;
                    s_sel_d = id_to_sel({id_hi_q, g_addr});
                    if ({id_hi_q, g_addr} == SLAVE_NONE) begin
                        decode_err_d = 1'b1;
                    end
                end
                StRoute: begin
                    // New transfer on a fresh valid_s rising edge; keep old s_sel
                    // until the new address is fully decoded.
                    if (g_valid && !valid_prev_q) begin
                        state_d = StAddr0;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    bus_ready_d = '0;
                    s_sel_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_id_q    <= 1'b0;
            last_q        <= 1'b1;  // master 0 wins the first contention
            timer_q       <= '0;
            valid_prev_q  <= 1'b0;
            bus_ready_q   <= '0;
            s_sel_q       <= '0;
            id_hi_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            decode_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_q        <= last_d;
            timer_q       <= timer_d;
            valid_prev_q  <= valid_prev_d;
            bus_ready_q   <= bus_ready_d;
            s_sel_q       <= s_sel_d;
            id_hi_q       <= id_hi_d;
            timeout_err_q <= timeout_err_d;
            decode_err_q  <= decode_err_d;
        end
    end

    assign granted      = bus_ready_q[grant_id_q];
    assign route_active = granted && (s_sel_q != '0);
    assign sel_id       = sel_to_id(s_sel_q);

    // Forward path: granted master's lines, gated by the registered grant so
    // an asynchronous reset silences the slaves immediately.
    always_comb begin
        s_addr_tx    = granted & m_addr_tx[grant_id_q];
        s_data_tx    = granted & m_data_tx[grant_id_q];
        s_valid_s    = granted & m_valid_s[grant_id_q];
        s_write_en   = granted & m_write_en[grant_id_q];
        s_burst_mode = granted & m_burst_mode[grant_id_q];
    end

    // Return path: only the granted master sees the selected slave.
    always_comb begin
        m_data_rx     = '0;
        m_slave_ready = '0;
        m_slave_valid = '0;
        if (route_active && sel_id != SLAVE_NONE) begin
            m_data_rx[grant_id_q]     = s_data_rx[sel_id];
            m_slave_ready[grant_id_q] = s_ready[sel_id];
            m_slave_valid[grant_id_q] = s_valid_rsp[sel_id];
        end
    end

    assign m_bus_ready = bus_ready_q;
    assign s_sel       = s_sel_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;
    assign decode_err  = decode_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a table of per-cycle vectors
// (inputs driven on the falling edge, outputs checked 1 time unit after the
// rising edge) plus hand-written timeout and reset-mid-transfer sequences.
module tb_bus_arbiter;

    logic       clock;
    logic       reset;
    logic [1:0] m_bus_req, m_addr_tx, m_data_tx, m_valid_s, m_write_en, m_burst_mode;
    logic [1:0] m_bus_ready, m_data_rx, m_slave_ready, m_slave_valid;
    logic       s_addr_tx, s_data_tx, s_valid_s, s_write_en, s_burst_mode;
    logic [2:0] s_sel, s_data_rx, s_ready, s_valid_rsp;
    logic       grant_id, timeout_err, decode_err;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.TIMEOUT(64)) dut (
        .clock         (clock),
        .reset         (reset),
        .m_bus_req     (m_bus_req),
        .m_addr_tx     (m_addr_tx),
        .m_data_tx     (m_data_tx),
        .m_valid_s     (m_valid_s),
        .m_write_en    (m_write_en),
        .m_burst_mode  (m_burst_mode),
        .m_bus_ready   (m_bus_ready),
        .m_data_rx     (m_data_rx),
        .m_slave_ready (m_slave_ready),
        .m_slave_valid (m_slave_valid),
        .s_addr_tx     (s_addr_tx),
        .s_data_tx     (s_data_tx),
        .s_valid_s     (s_valid_s),
        .s_write_en    (s_write_en),
        .s_burst_mode  (s_burst_mode),
        .s_sel         (s_sel),
        .s_data_rx     (s_data_rx),
        .s_ready       (s_ready),
        .s_valid_rsp   (s_valid_rsp),
        .grant_id      (grant_id),
        .timeout_err   (timeout_err),
        .decode_err    (decode_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [1:0] req, valid, addr, data, we, burst;
        logic [2:0] sdrx, srdy, svld;
        logic [1:0] e_ready;
        logic [2:0] e_sel;
        logic       e_gid, e_terr, e_derr;
        logic [1:0] e_mdrx, e_mrdy, e_mvld;
        logic [4:0] e_sfwd;  // {addr, data, valid, write_en, burst}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] req, valid, addr, data, we, burst,
                       input logic [2:0] sdrx, srdy, svld,
                       input logic [1:0] e_ready, input logic [2:0] e_sel,
                       input logic e_gid, e_terr, e_derr,
                       input logic [1:0] e_mdrx, e_mrdy, e_mvld, input logic [4:0] e_sfwd);
        vec_t v;
        v.rst = rst; v.req = req; v.valid = valid; v.addr = addr; v.data = data;
        v.we = we; v.burst = burst; v.sdrx = sdrx; v.srdy = srdy; v.svld = svld;
        v.e_ready = e_ready; v.e_sel = e_sel; v.e_gid = e_gid; v.e_terr = e_terr;
        v.e_derr = e_derr; v.e_mdrx = e_mdrx; v.e_mrdy = e_mrdy; v.e_mvld = e_mvld;
        v.e_sfwd = e_sfwd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] sfwd();
        return {s_addr_tx, s_data_tx, s_valid_s, s_write_en, s_burst_mode};
    endfunction

    task automatic clear_inputs();
        m_bus_req = '0; m_addr_tx = '0; m_data_tx = '0; m_valid_s = '0;
        m_write_en = '0; m_burst_mode = '0;
        s_data_rx = '0; s_ready = '0; s_valid_rsp = '0;
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] ready,
                                 input logic [2:0] sel, input logic gid,
                                 input logic [1:0] mdrx, input logic [4:0] fwd);
        chk({tag, "_ready"}, 8'(m_bus_ready), 8'(ready));
        chk({tag, "_sel"}, 8'(s_sel), 8'(sel));
        chk({tag, "_gid"}, 8'(grant_id), 8'(gid));
        chk({tag, "_mdrx"}, 8'(m_data_rx), 8'(mdrx));
        chk({tag, "_sfwd"}, 8'(sfwd()), 8'(fwd));
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();

        // rst req valid addr data we burst sdrx srdy svld | ready sel gid terr derr mdrx mrdy mvld sfwd
        // M0 alone, address 01 -> slave 1, return from slave 1 only
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b01, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b01, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b01100);
        add(0, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b01, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00100);
        add(0, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 3'b010, 3'b101, 3'b010,
            2'b01, 3'b010, 0, 0, 0, 2'b01, 2'b00, 2'b01, 5'b10110);
        add(0, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 3'b101, 3'b010, 3'b101,
            2'b01, 3'b010, 0, 0, 0, 2'b00, 2'b01, 2'b00, 5'b01101);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b111, 3'b111, 3'b111,
            2'b00, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        // Contention after reset -> M0; handover -> M1; release+new request same cycle
        add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b01, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b10, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b10, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b01100);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b10, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b01, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b10, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        // M1 address 11 -> no slave, decode_err pulse, return lines 0
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b10, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b10, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00100);
        add(0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b10, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b10100);
        add(0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 3'b111, 3'b111, 3'b111,
            2'b10, 3'b000, 1, 0, 1, 2'b00, 2'b00, 2'b00, 5'b10100);
        add(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3'b111, 3'b111, 3'b111,
            2'b10, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00100);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 1, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        // M0 prefix 01 then, after a valid_s gap, prefix 00: re-decode 010 -> 001
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b01, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b01, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00100);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b01, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00100);
        add(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b01, 3'b010, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b10100);
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 3'b010, 3'b010,
            2'b01, 3'b010, 0, 0, 0, 2'b01, 2'b01, 2'b01, 5'b00000);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 3'b010, 3'b010,
            2'b01, 3'b010, 0, 0, 0, 2'b01, 2'b01, 2'b01, 5'b00100);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 3'b001, 3'b001,
            2'b01, 3'b010, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00100);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 3'b001, 3'b001,
            2'b01, 3'b001, 0, 0, 0, 2'b01, 2'b01, 2'b01, 5'b00100);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 3'b000,
            2'b00, 3'b000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'b00000);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("row%0d", i);
            @(negedge clock);
            reset = vecs[i].rst;
            m_bus_req = vecs[i].req; m_valid_s = vecs[i].valid; m_addr_tx = vecs[i].addr;
            m_data_tx = vecs[i].data; m_write_en = vecs[i].we; m_burst_mode = vecs[i].burst;
            s_data_rx = vecs[i].sdrx; s_ready = vecs[i].srdy; s_valid_rsp = vecs[i].svld;
            @(posedge clock);
            #1;
            check_outputs(tag, vecs[i].e_ready, vecs[i].e_sel, vecs[i].e_gid,
                          vecs[i].e_mdrx, vecs[i].e_sfwd);
            chk({tag, "_terr"}, 8'(timeout_err), 8'(vecs[i].e_terr));
            chk({tag, "_derr"}, 8'(decode_err), 8'(vecs[i].e_derr));
            chk({tag, "_mrdy"}, 8'(m_slave_ready), 8'(vecs[i].e_mrdy));
            chk({tag, "_mvld"}, 8'(m_slave_valid), 8'(vecs[i].e_mvld));
        end

        // Timeout: M1 granted, never raises valid_s
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        reset = 1'b0;
        m_bus_req = 2'b10;
        @(posedge clock);
        #1;
        chk("to_grant", 8'(m_bus_ready), 8'(2'b10));
        for (int i = 1; i <= 64; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("to_ready_%0d", i), 8'(m_bus_ready), (i == 64) ? 8'h00 : 8'h02);
            chk($sformatf("to_err_%0d", i), 8'(timeout_err), (i == 64) ? 8'h01 : 8'h00);
        end
        @(posedge clock);
        #1;
        chk("to_regrant", 8'(m_bus_ready), 8'(2'b10));
        chk("to_err_clear", 8'(timeout_err), 8'h00);
        chk("to_gid", 8'(grant_id), 8'h01);

        // Reset in the middle of a write routed to slave 2
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        reset = 1'b0;
        m_bus_req = 2'b01;
        @(posedge clock);
        #1;
        chk("rw_grant", 8'(m_bus_ready), 8'(2'b01));
        @(negedge clock);
        m_valid_s = 2'b01;
        @(negedge clock);
        m_addr_tx = 2'b01;
        @(negedge clock);
        m_addr_tx = 2'b00;
        @(posedge clock);
        #1;
        chk("rw_sel", 8'(s_sel), 8'(3'b100));
        @(negedge clock);
        m_write_en = 2'b01;
        m_data_tx = 2'b01;
        s_data_rx = 3'b100;
        #1;
        chk("rw_sfwd", 8'(sfwd()), 8'(5'b01110));
        chk("rw_mdrx", 8'(m_data_rx), 8'(2'b01));
        #2;
        reset = 1'b1;
        #1;
        check_outputs("rw_async", 2'b00, 3'b000, 1'b0, 2'b00, 5'b00000);
        @(posedge clock);
        #1;
        check_outputs("rw_held", 2'b00, 3'b000, 1'b0, 2'b00, 5'b00000);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rw_regrant", 8'(m_bus_ready), 8'(2'b01));
        chk("rw_regrant_sel", 8'(s_sel), 8'(3'b000));

        @(negedge clock);
        clear_inputs();
        @(posedge clock);
        #1;
        chk("end_release", 8'(m_bus_ready), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
